// File: rtl/candidate_selector.sv
// Scans the per-window hit counts from hash_table one entry per cycle and reports the
// best window (highest count, lowest index on ties) plus how many windows meet a threshold.
module candidate_selector #(
   parameter int NUM_OF_WINDOWS      = 1024,
   parameter int LOG2_NUM_OF_WINDOWS = 10,
   parameter int COUNT_WIDTH         = 32
) (
   input  logic                           clk,
   input  logic                           reset_candidate_selector,
   input  logic                           start,
   input  logic [COUNT_WIDTH-1:0]         min_count,
   input  logic [COUNT_WIDTH-1:0]         count_bus [0:NUM_OF_WINDOWS-1],
   output logic                           busy,
   output logic                           done,
   output logic                           found,
   output logic [31:0]                    best_window_id,
   output logic [COUNT_WIDTH-1:0]         best_count,
   output logic [LOG2_NUM_OF_WINDOWS:0]   num_candidates
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                           state_reg;
   state_t                           state_next;
   logic [LOG2_NUM_OF_WINDOWS-1:0]   idx_reg;
   logic [COUNT_WIDTH-1:0]           thr_reg;
   logic                             have_best_reg;

   logic [COUNT_WIDTH-1:0]           cur_count;
   logic                             qualify;
   logic                             better;
   logic                             last_idx;

   // Entries are read live so an update landing before the scan reaches it is honoured.
   always_comb begin
      state_next = state_reg;
      cur_count  = count_bus[idx_reg];
      qualify    = (cur_count >= thr_reg);
      // Strict greater-than keeps the lowest index on ties.
      better     = qualify && (!have_best_reg || (cur_count > best_count));
      last_idx   = (idx_reg == LOG2_NUM_OF_WINDOWS'(NUM_OF_WINDOWS - 1));
      case (state_reg)
         IDLE:    if (start) state_next = SCAN;
         SCAN:    if (last_idx) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);

   always_ff @(posedge clk or posedge reset_candidate_selector) begin
      if (reset_candidate_selector) begin
         state_reg      <= IDLE;
         idx_reg        <= '0;
         thr_reg        <= '0;
         have_best_reg  <= 1'b0;
         found          <= 1'b0;
         best_window_id <= '0;
         best_count     <= '0;
         num_candidates <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  idx_reg        <= '0;
                  thr_reg        <= min_count;
                  have_best_reg  <= 1'b0;
                  found          <= 1'b0;
                  best_window_id <= '0;
                  best_count     <= '0;
                  num_candidates <= '0;
               end
            end
            SCAN: begin
               if (qualify) begin
                  num_candidates <= num_candidates + 1'b1;
                  found          <= 1'b1;
               end
               if (better) begin
                  best_window_id <= {{(32 - LOG2_NUM_OF_WINDOWS){1'b0}}, idx_reg};
                  best_count     <= cur_count;
                  have_best_reg  <= 1'b1;
               end
               if (!last_idx) idx_reg <= idx_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_candidate_selector.sv
// Directed bench for candidate_selector: a 16-window instance for the vector table and
// handshake sequences, and a default 1024-window instance for the reset and full-size runs.
module tb_candidate_selector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        s_rst, s_start, s_busy, s_done, s_found;
   logic [31:0] s_min, s_id, s_best;
   logic [31:0] s_bus [0:15];
   logic [4:0]  s_num;

   logic        l_rst, l_start, l_busy, l_done, l_found;
   logic [31:0] l_min, l_id, l_best;
   logic [31:0] l_bus [0:1023];
   logic [10:0] l_num;

   candidate_selector #(
      .NUM_OF_WINDOWS(16), .LOG2_NUM_OF_WINDOWS(4), .COUNT_WIDTH(32)
   ) dut_s (
      .clk(clk), .reset_candidate_selector(s_rst), .start(s_start), .min_count(s_min),
      .count_bus(s_bus), .busy(s_busy), .done(s_done), .found(s_found),
      .best_window_id(s_id), .best_count(s_best), .num_candidates(s_num)
   );

   candidate_selector dut_l (
      .clk(clk), .reset_candidate_selector(l_rst), .start(l_start), .min_count(l_min),
      .count_bus(l_bus), .busy(l_busy), .done(l_done), .found(l_found),
      .best_window_id(l_id), .best_count(l_best), .num_candidates(l_num)
   );

   typedef struct packed {
      logic [15:0][7:0] counts;
      logic [31:0]      thr;
      logic             exp_found;
      logic [31:0]      exp_id;
      logic [31:0]      exp_best;
      logic [4:0]       exp_num;
   } vec_t;

   vec_t vecs [7];

   int s_done_cnt = 0;
   int l_done_cnt = 0;
   always @(negedge clk) begin
      if (s_done === 1'b1) s_done_cnt++;
      if (l_done === 1'b1) l_done_cnt++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] thr, input logic f, input logic [31:0] id,
                               input logic [31:0] best, input logic [4:0] num);
      vec_t v;
      v = '0;
      v.thr = thr; v.exp_found = f; v.exp_id = id; v.exp_best = best; v.exp_num = num;
      return v;
   endfunction

   // Called at the first negedge after the accepting edge; counts edges including that one.
   task automatic wait_done_s(output int lat);
      lat = 1;
      while (s_done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_done_l(output int lat);
      lat = 1;
      while (l_done !== 1'b1 && lat < 2000) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_small(input int n, input vec_t v);
      int lat;
      for (int i = 0; i < 16; i++) s_bus[i] = 32'(v.counts[i]);
      s_min = v.thr;
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      chk($sformatf("v%0d_busy", n), 64'(s_busy), 64'd1);
      wait_done_s(lat);
      chk($sformatf("v%0d_latency", n), 64'(lat), 64'd17);
      chk($sformatf("v%0d_found", n), 64'(s_found), 64'(v.exp_found));
      chk($sformatf("v%0d_id", n), 64'(s_id), 64'(v.exp_id));
      chk($sformatf("v%0d_best", n), 64'(s_best), 64'(v.exp_best));
      chk($sformatf("v%0d_num", n), 64'(s_num), 64'(v.exp_num));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", n), 64'(s_done), 64'd0);
      $display("vector %0d thr=%0d found=%0d id=%0d best=%0d num=%0d lat=%0d",
               n, v.thr, s_found, s_id, s_best, s_num, lat);
   endtask

   initial begin
      int lat;
      int base;

      vecs[0] = mk(1, 1'b1, 14, 16, 1);
      vecs[0].counts[14] = 8'd16;
      vecs[1] = mk(3, 1'b1, 7, 9, 3);
      vecs[1].counts[3] = 8'd5; vecs[1].counts[7] = 8'd9;
      vecs[1].counts[9] = 8'd9; vecs[1].counts[12] = 8'd2;
      vecs[2] = mk(5, 1'b0, 0, 0, 0);
      vecs[3] = mk(0, 1'b1, 0, 4, 16);
      for (int i = 0; i < 16; i++) begin
         vecs[2].counts[i] = 8'd4;
         vecs[3].counts[i] = 8'd4;
      end
      vecs[4] = mk(0, 1'b1, 0, 0, 16);
      vecs[5] = mk(15, 1'b1, 15, 15, 1);
      vecs[6] = mk(10, 1'b1, 0, 20, 11);
      for (int i = 0; i < 16; i++) begin
         vecs[5].counts[i] = 8'(i);
         vecs[6].counts[i] = 8'(20 - i);
      end

      s_rst = 1'b1; l_rst = 1'b1; s_start = 1'b0; l_start = 1'b0;
      s_min = '0; l_min = '0;
      for (int i = 0; i < 16; i++) s_bus[i] = '0;
      for (int i = 0; i < 1024; i++) l_bus[i] = 32'(i);
      #2;
      chk("rst_busy", 64'(s_busy), 64'd0);
      chk("rst_done", 64'(s_done), 64'd0);
      chk("rst_found", 64'(s_found), 64'd0);
      chk("rst_id", 64'(s_id), 64'd0);
      chk("rst_best", 64'(s_best), 64'd0);
      chk("rst_num", 64'(s_num), 64'd0);
      @(negedge clk); @(negedge clk);
      s_rst = 1'b0; l_rst = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 7; n++) run_small(n, vecs[n]);

      // Start held for five cycles, then re-pulsed during DONE: one scan only.
      for (int i = 0; i < 16; i++) s_bus[i] = 32'(vecs[1].counts[i]);
      s_min = vecs[1].thr;
      base = s_done_cnt;
      @(negedge clk); s_start = 1'b1;
      repeat (5) @(negedge clk);
      s_start = 1'b0;
      lat = 0;
      while (s_done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("hs_done_seen", 64'(s_done), 64'd1);
      s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      chk("hs_busy_after_done", 64'(s_busy), 64'd0);
      repeat (10) @(negedge clk);
      chk("hs_one_pulse", 64'(s_done_cnt - base), 64'd1);
      chk("hs_idle", 64'(s_busy), 64'd0);
      chk("hs_hold_id", 64'(s_id), 64'd7);
      chk("hs_hold_best", 64'(s_best), 64'd9);
      chk("hs_hold_num", 64'(s_num), 64'd3);
      chk("hs_hold_found", 64'(s_found), 64'd1);
      $display("handshake pulses=%0d id=%0d best=%0d num=%0d", s_done_cnt - base, s_id, s_best, s_num);

      // New start clears results at acceptance, before any entry is evaluated.
      for (int i = 0; i < 16; i++) s_bus[i] = 32'(vecs[0].counts[i]);
      s_min = 32'd1;
      @(negedge clk); s_start = 1'b1;
      @(negedge clk); s_start = 1'b0;
      chk("clr_id", 64'(s_id), 64'd0);
      chk("clr_best", 64'(s_best), 64'd0);
      chk("clr_num", 64'(s_num), 64'd0);
      chk("clr_found", 64'(s_found), 64'd0);
      wait_done_s(lat);
      chk("clr_latency", 64'(lat), 64'd17);
      chk("clr_id_final", 64'(s_id), 64'd14);
      $display("clear-at-start id=%0d best=%0d num=%0d lat=%0d", s_id, s_best, s_num, lat);

      // Full-size instance: reset 300 cycles into a scan aborts with no done pulse.
      l_min = 32'd1000;
      @(negedge clk); l_start = 1'b1;
      @(negedge clk); l_start = 1'b0;
      repeat (299) @(negedge clk);
      chk("abort_busy_before", 64'(l_busy), 64'd1);
      base = l_done_cnt;
      l_rst = 1'b1;
      #1;
      chk("abort_busy", 64'(l_busy), 64'd0);
      chk("abort_done", 64'(l_done), 64'd0);
      chk("abort_found", 64'(l_found), 64'd0);
      chk("abort_id", 64'(l_id), 64'd0);
      chk("abort_best", 64'(l_best), 64'd0);
      chk("abort_num", 64'(l_num), 64'd0);
      @(negedge clk); @(negedge clk);
      l_rst = 1'b0;
      repeat (1100) @(negedge clk);
      chk("abort_no_done", 64'(l_done_cnt - base), 64'd0);
      chk("abort_idle", 64'(l_busy), 64'd0);
      $display("abort pulses=%0d busy=%0d", l_done_cnt - base, l_busy);

      @(negedge clk); l_start = 1'b1;
      @(negedge clk); l_start = 1'b0;
      wait_done_l(lat);
      chk("full_latency", 64'(lat), 64'd1025);
      chk("full_found", 64'(l_found), 64'd1);
      chk("full_id", 64'(l_id), 64'd1023);
      chk("full_best", 64'(l_best), 64'd1023);
      chk("full_num", 64'(l_num), 64'd24);
      @(negedge clk);
      chk("full_done_pulse", 64'(l_done), 64'd0);
      $display("full id=%0d best=%0d num=%0d lat=%0d", l_id, l_best, l_num, lat);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/candidate_selector.md
Name: candidate_selector

Overview:
- Sits directly downstream of hash_table.
- After a query, hash_table's count_bus holds one 32-bit hit count per window.
- This block scans count_bus one entry per cycle and reports the best-matching window (highest count, lowest index on ties) and how many windows reach a minimum-count threshold.
- Results feed the top-level mapping controller.

Parameters:
- NUM_OF_WINDOWS, 1024: number of count_bus entries scanned.
- LOG2_NUM_OF_WINDOWS, 10: index width.
- COUNT_WIDTH, 32: width of each count and of best_count.

Ports:
- clk  input  1  single clock, rising edge.
- reset_candidate_selector  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; accepted only in IDLE.
- min_count  input  COUNT_WIDTH  threshold; sampled at start acceptance.
- count_bus  input  [COUNT_WIDTH-1:0] x [0:NUM_OF_WINDOWS-1]  per-window counts from hash_table.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse; results final.
- found  output  1  at least one window met the threshold.
- best_window_id  output  32  index of the best window; zero-extended.
- best_count  output  COUNT_WIDTH  count of the best window.
- num_candidates  output  LOG2_NUM_OF_WINDOWS+1  number of windows with count >= threshold.

Behaviour:
- Reset, asynchronous, active-high:
  - state=IDLE, idx=0.
  - Outputs busy, done, found, best_window_id, best_count, num_candidates all 0.
  - Reset mid-scan aborts immediately; no done pulse is produced.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If start=1 at edge E0, go to SCAN.
  - At E0: idx=0, latch min_count into thr_q, clear best_window_id, best_count, num_candidates, found, have_best.
  - Otherwise hold all outputs, so previous results remain readable.
- SCAN, at each edge, with c = count_bus[idx] sampled live:
  - If c >= thr_q: num_candidates += 1 and found=1.
  - If c >= thr_q and (have_best=0 or c > best_count): best_window_id=idx, best_count=c, have_best=1.
  - Strict greater-than means the lowest index wins a tie.
  - If idx == NUM_OF_WINDOWS-1, go to DONE; otherwise idx += 1.
- DONE: done=1 for exactly this one cycle, then go to IDLE.
- Latency:
  - Start accepted at E0; the last entry is evaluated at edge E_N, with N = NUM_OF_WINDOWS.
  - done is high in the cycle following E_N.
  - Total: start to done = NUM_OF_WINDOWS+1 cycles.
- busy=1 from the edge after E0 through the DONE cycle inclusive.
- start while busy, including the DONE cycle, is ignored with no queuing.
- Data stability: the upstream controller holds count_bus stable (no insert/query) while busy. Entries are read live, so an entry changed before it is scanned uses its new value.
- min_count=0: every window qualifies. num_candidates = NUM_OF_WINDOWS; found=1; best is the first maximum, even when all counts are 0.
- num_candidates has one extra bit, so the count NUM_OF_WINDOWS is representable with no wrap.
- No arithmetic overflow is possible beyond this.
- Partial results are visible on the outputs during SCAN; they are valid only when done=1 or in IDLE afterwards.

Test Plan:
- Reset check: assert reset mid-scan at cycle 300 of a default run -> all outputs 0 next cycle, state IDLE, no done pulse; a later start completes normally.
- Basic max: NUM_OF_WINDOWS=16, count_bus all 0 except [14]=16, min_count=1, pulse start -> done exactly 17 cycles after acceptance; best_window_id=14, best_count=16, num_candidates=1, found=1.
- Tie-break and threshold: counts [3]=5, [7]=9, [9]=9, [12]=2; min_count=3 -> best_window_id=7, best_count=9, num_candidates=3.
- Nothing qualifies: all counts 4, min_count=5 -> found=0, num_candidates=0, best_window_id=0, best_count=0.
  - Same counts with min_count=0 -> found=1, num_candidates=16, best_window_id=0, best_count=4.
- Handshake: start held high for 5 cycles, then pulsed again during DONE -> exactly one scan and one done pulse.
  - Results hold in IDLE for 10 idle cycles.
  - A new start clears the results at acceptance.
- Full size (default 1024): count_bus[i]=i, min_count=1000 -> best_window_id=1023, best_count=1023, num_candidates=24, done 1025 cycles after acceptance.
